// File: rtl/two_of_five_pkg.sv
// Shared code words and FSM encoding for the 2-of-5 display link transmitter.
// Code weights a=1 b=2 c=4 d=7 e=0; zero uses c+d (11) so every word has two ones.
package two_of_five_pkg;

   localparam logic [4:0] CODE_0 = 5'b00110;
   localparam logic [4:0] CODE_1 = 5'b10001;
   localparam logic [4:0] CODE_2 = 5'b01001;
   localparam logic [4:0] CODE_3 = 5'b11000;
   localparam logic [4:0] CODE_4 = 5'b00101;
   localparam logic [4:0] CODE_5 = 5'b10100;
   localparam logic [4:0] CODE_6 = 5'b01100;
   localparam logic [4:0] CODE_7 = 5'b00011;
   localparam logic [4:0] CODE_8 = 5'b10010;
   localparam logic [4:0] CODE_9 = 5'b01010;

   localparam logic [2:0] LAST_BIT = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GUARD = 2'd2
   } state_e;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/two_of_five_enc.sv
// Combinational BCD to 2-of-5 encoder; zero latency, no handshake.
// Digits 10..15 give ok=0 and an all-zero code.
module two_of_five_enc
   import two_of_five_pkg::*;
(
   input  logic [3:0] in_digit,
   output logic [4:0] code,
   output logic       ok
);

   always_comb begin
      code = 5'b00000;
      ok   = 1'b1;
      case (in_digit)
         4'd0:    code = CODE_0;
         4'd1:    code = CODE_1;
         4'd2:    code = CODE_2;
         4'd3:    code = CODE_3;
         4'd4:    code = CODE_4;
         4'd5:    code = CODE_5;
         4'd6:    code = CODE_6;
         4'd7:    code = CODE_7;
         4'd8:    code = CODE_8;
         4'd9:    code = CODE_9;
         default: ok   = 1'b0;
      endcase
   end

endmodule

// File: rtl/two_of_five_tx.sv
// 2-of-5 source: one digit per accept, parallel word next cycle, serial frame a..e then guard gap.
// in_ready is low from accept until the first IDLE cycle; period 1 + 5*BIT_CYCLES + GUARD_CYCLES.
module two_of_five_tx
   import two_of_five_pkg::*;
#(
   parameter int BIT_CYCLES   = 4,
   parameter int GUARD_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [3:0] in_digit,
   output logic       in_ready,
   output logic [4:0] word,
   output logic       v,
   output logic       err,
   output logic       ser_out,
   output logic       ser_frame,
   output logic       busy
);

   localparam int CNT_W = $clog2(max_of(BIT_CYCLES, GUARD_CYCLES) + 1);
   localparam logic [CNT_W-1:0] BIT_RELOAD   = CNT_W'(BIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GUARD_RELOAD = (GUARD_CYCLES > 0) ? CNT_W'(GUARD_CYCLES - 1) : '0;

   state_e           state_q, state_d;
   logic [4:0]       word_q, word_d;
   logic             v_q, v_d;
   logic             err_q, err_d;
   logic [4:0]       shreg_q, shreg_d;
   logic [2:0]       bit_q, bit_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ser_out_q, ser_out_d;
   logic             ser_frame_q, ser_frame_d;
   logic             busy_q, busy_d;

   logic [4:0] enc_code;
   logic       enc_ok;
   logic       accept;

   two_of_five_enc u_enc (
      .in_digit (in_digit),
      .code     (enc_code),
      .ok       (enc_ok)
   );

   assign in_ready = (state_q == ST_IDLE) && !rst;
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      v_d     = v_q;
      err_d   = 1'b0;
      shreg_d = shreg_q;
      bit_d   = bit_q;
      cnt_d   = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               word_d = enc_code;
               v_d    = enc_ok;
               err_d  = !enc_ok;
               // An invalid digit only updates the parallel side; no frame.
               if (enc_ok) begin
                  state_d = ST_SHIFT;
                  shreg_d = enc_code;
                  bit_d   = 3'd0;
                  cnt_d   = BIT_RELOAD;
               end
            end
         end
         ST_SHIFT: begin
            if (cnt_q == '0) begin
               if (bit_q == LAST_BIT) begin
                  if (GUARD_CYCLES > 0) begin
                     state_d = ST_GUARD;
                     cnt_d   = GUARD_RELOAD;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shreg_d = {shreg_q[3:0], 1'b0};
                  cnt_d   = BIT_RELOAD;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_GUARD: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Line outputs are registered from the next state so they align with it.
      ser_frame_d = (state_d == ST_SHIFT);
      ser_out_d   = ser_frame_d && shreg_d[4];
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         word_q      <= 5'b00000;
         v_q         <= 1'b0;
         err_q       <= 1'b0;
         shreg_q     <= 5'b00000;
         bit_q       <= 3'd0;
         cnt_q       <= '0;
         ser_out_q   <= 1'b0;
         ser_frame_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         v_q         <= v_d;
         err_q       <= err_d;
         shreg_q     <= shreg_d;
         bit_q       <= bit_d;
         cnt_q       <= cnt_d;
         ser_out_q   <= ser_out_d;
         ser_frame_q <= ser_frame_d;
         busy_q      <= busy_d;
      end
   end

   assign word      = word_q;
   assign v         = v_q;
   assign err       = err_q;
   assign ser_out   = ser_out_q;
   assign ser_frame = ser_frame_q;
   assign busy      = busy_q;

   a_two_hot : assert property (@(posedge clk) disable iff (rst) v_q |-> ($countones(word_q) == 2));

endmodule
